// File: rtl/iob_axis_packer.sv
// Packs narrow AXI-Stream beats into full-width words for the DMA input path.
// It keeps a lane-valid mask, flushes a partial word on tlast, and counts the words accepted downstream.
module iob_axis_packer #(
   parameter  int IN_W  = 8,
   parameter  int OUT_W = 32,
   parameter  int CNT_W = 32,
   localparam int RATIO = OUT_W / IN_W
) (
   input  logic             clk_i,
   input  logic             cke_i,
   input  logic             arst_i,
   input  logic             rst_i,
   input  logic [IN_W-1:0]  in_tdata_i,
   input  logic             in_tvalid_i,
   input  logic             in_tlast_i,
   output logic             in_tready_o,
   output logic [OUT_W-1:0] out_tdata_o,
   output logic [RATIO-1:0] out_tkeep_o,
   output logic             out_tlast_o,
   output logic             out_tvalid_o,
   input  logic             out_tready_i,
   output logic [CNT_W-1:0] word_cnt_o
);

   localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

   logic [OUT_W-1:0]  acc;
   logic [RATIO-1:0]  keep_acc;
   logic [LANE_W-1:0] lane;
   logic [OUT_W-1:0]  merged_data;
   logic [RATIO-1:0]  merged_keep;
   logic              acc_fire;
   logic              out_fire;
   logic              word_done;

   // A new beat may enter whenever the holding register is empty or is draining this cycle.
   assign in_tready_o = cke_i & (~out_tvalid_o | out_tready_i);
   assign acc_fire    = in_tvalid_i & in_tready_o;
   assign out_fire    = out_tvalid_o & out_tready_i & cke_i;
   assign word_done   = acc_fire & ((lane == LAST_LANE) | in_tlast_i);

   // Lanes that are not yet filled are still zero in acc, so the merge only has to drop the new beat into place.
   always_comb begin
      merged_data = acc;
      merged_keep = keep_acc;
      for (int k = 0; k < RATIO; k++) begin
         if (lane == LANE_W'(k)) begin
            merged_data[k*IN_W +: IN_W] = in_tdata_i;
            merged_keep[k]              = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         acc      <= '0;
         keep_acc <= '0;
         lane     <= '0;
      end else if (cke_i) begin
         if (rst_i) begin
            acc      <= '0;
            keep_acc <= '0;
            lane     <= '0;
         end else if (word_done) begin
            acc      <= '0;
            keep_acc <= '0;
            lane     <= '0;
         end else if (acc_fire) begin
            acc      <= merged_data;
            keep_acc <= merged_keep;
            lane     <= lane + LANE_W'(1);
         end
      end
   end

   // A completion reloads the holding register even while it drains, so back-to-back words see no bubble.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         out_tdata_o  <= '0;
         out_tkeep_o  <= '0;
         out_tlast_o  <= 1'b0;
         out_tvalid_o <= 1'b0;
      end else if (cke_i) begin
         if (rst_i) begin
            out_tdata_o  <= '0;
            out_tkeep_o  <= '0;
            out_tlast_o  <= 1'b0;
            out_tvalid_o <= 1'b0;
         end else if (word_done) begin
            out_tdata_o  <= merged_data;
            out_tkeep_o  <= merged_keep;
            out_tlast_o  <= in_tlast_i;
            out_tvalid_o <= 1'b1;
         end else if (out_fire) begin
            out_tvalid_o <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         word_cnt_o <= '0;
      end else if (cke_i) begin
         if (rst_i) begin
            word_cnt_o <= '0;
         end else if (out_fire) begin
            word_cnt_o <= word_cnt_o + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_iob_axis_packer.sv
// Bench for iob_axis_packer (8 -> 32 bits): a table of packets and a word scoreboard, plus hand-written reset, stall and clock-enable sequences.
// A second instance with a 4-bit counter runs alongside the first to exercise counter wrap.
module tb_iob_axis_packer;

   typedef struct {
      int               nb;
      logic [3:0][7:0]  b;
      logic             tl;
      logic [31:0]      ed;
      logic [3:0]       ek;
      logic             el;
   } vec_t;

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
   } word_t;

   logic        clk = 1'b0;
   logic        cke, arst, rst;
   logic [7:0]  in_tdata;
   logic        in_tvalid, in_tlast, in_tready;
   logic [31:0] out_tdata;
   logic [3:0]  out_tkeep;
   logic        out_tlast, out_tvalid, out_tready;
   logic [31:0] wc;
   logic        in_tready4, out_tlast4, out_tvalid4;
   logic [31:0] out_tdata4;
   logic [3:0]  out_tkeep4;
   logic [3:0]  wc4;
   logic        rdy_fixed, tog_en, tog_rdy, mon_en;
   logic [3:0]  tog_pat = 4'b1001;
   int          tog_idx;
   int          n_cmp = 0;
   int          n_bad = 0;
   word_t       sb[$];
   vec_t        vecs[6];

   assign out_tready = tog_en ? tog_rdy : rdy_fixed;

   iob_axis_packer #(.IN_W(8), .OUT_W(32), .CNT_W(32)) u_dut (
      .clk_i(clk), .cke_i(cke), .arst_i(arst), .rst_i(rst),
      .in_tdata_i(in_tdata), .in_tvalid_i(in_tvalid), .in_tlast_i(in_tlast),
      .in_tready_o(in_tready), .out_tdata_o(out_tdata), .out_tkeep_o(out_tkeep),
      .out_tlast_o(out_tlast), .out_tvalid_o(out_tvalid), .out_tready_i(out_tready),
      .word_cnt_o(wc));

   iob_axis_packer #(.IN_W(8), .OUT_W(32), .CNT_W(4)) u_dut4 (
      .clk_i(clk), .cke_i(cke), .arst_i(arst), .rst_i(rst),
      .in_tdata_i(in_tdata), .in_tvalid_i(in_tvalid), .in_tlast_i(in_tlast),
      .in_tready_o(in_tready4), .out_tdata_o(out_tdata4), .out_tkeep_o(out_tkeep4),
      .out_tlast_o(out_tlast4), .out_tvalid_o(out_tvalid4), .out_tready_i(out_tready),
      .word_cnt_o(wc4));

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Drives one beat and holds it until the DUT takes it; returns just after the accepting edge.
   task automatic applyStimulus(input logic [7:0] d, input logic l);
      logic took = 1'b0;
      int   guard = 0;
      in_tdata  = d;
      in_tlast  = l;
      in_tvalid = 1'b1;
      while (!took && guard < 100) begin
         @(negedge clk);
         took = in_tready;
         @(posedge clk);
         #1;
         guard++;
      end
      if (!took) checkOutput("accept_timeout", 64'(took), 64'd1);
      in_tvalid = 1'b0;
      in_tlast  = 1'b0;
   endtask

   task automatic pushWord(input logic [31:0] d, input logic [3:0] k, input logic l);
      word_t w;
      w.d = d;
      w.k = k;
      w.l = l;
      sb.push_back(w);
   endtask

   task automatic waitDrain();
      int g = 0;
      while ((sb.size() != 0 || out_tvalid) && g < 300) begin
         @(posedge clk);
         #1;
         g++;
      end
      checkOutput("drain", 64'(sb.size()), 64'd0);
   endtask

   task automatic softReset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      tog_rdy = 1'b1;
      tog_idx = 0;
      forever begin
         @(posedge clk);
         #1;
         if (tog_en) begin
            tog_rdy = tog_pat[tog_idx];
            tog_idx = (tog_idx + 1) % 4;
         end else begin
            tog_idx = 0;
         end
      end
   end

   // Scoreboard and stall monitor: sample half a cycle before the edge that performs the transfer.
   initial begin
      logic        prev_stall = 1'b0;
      logic [37:0] held = '0;
      word_t       e;
      forever begin
         @(negedge clk);
         if (mon_en && !arst && cke && !rst) begin
            if (out_tvalid && out_tready) begin
               if (sb.size() == 0) begin
                  checkOutput("unexpected_word", 64'(out_tvalid), 64'd0);
               end else begin
                  e = sb.pop_front();
                  checkOutput("word_data", 64'(out_tdata), 64'(e.d));
                  checkOutput("word_keep", 64'(out_tkeep), 64'(e.k));
                  checkOutput("word_last", 64'(out_tlast), 64'(e.l));
               end
            end
            if (out_tvalid && !out_tready) checkOutput("in_ready_stall", 64'(in_tready), 64'd0);
            if (prev_stall) checkOutput("stall_hold", 64'({out_tvalid, out_tlast, out_tkeep, out_tdata}), 64'(held));
            prev_stall = out_tvalid && !out_tready;
            held       = {out_tvalid, out_tlast, out_tkeep, out_tdata};
         end else begin
            prev_stall = 1'b0;
         end
      end
   end

   initial begin
      vecs[0] = '{nb:4, b:32'h44332211, tl:1'b0, ed:32'h44332211, ek:4'hF, el:1'b0};
      vecs[1] = '{nb:2, b:32'h0000BBAA, tl:1'b1, ed:32'h0000BBAA, ek:4'h3, el:1'b1};
      vecs[2] = '{nb:1, b:32'h0000005A, tl:1'b1, ed:32'h0000005A, ek:4'h1, el:1'b1};
      vecs[3] = '{nb:3, b:32'h00030201, tl:1'b1, ed:32'h00030201, ek:4'h7, el:1'b1};
      vecs[4] = '{nb:4, b:32'hEFBEADDE, tl:1'b1, ed:32'hEFBEADDE, ek:4'hF, el:1'b1};
      vecs[5] = '{nb:4, b:32'hFF00FF00, tl:1'b0, ed:32'hFF00FF00, ek:4'hF, el:1'b0};

      arst = 1'b1; cke = 1'b1; rst = 1'b0;
      in_tdata = '0; in_tvalid = 1'b0; in_tlast = 1'b0;
      rdy_fixed = 1'b1; tog_en = 1'b0; mon_en = 1'b0;
      #12;
      checkOutput("rst_valid", 64'(out_tvalid), 64'd0);
      checkOutput("rst_data", 64'(out_tdata), 64'd0);
      checkOutput("rst_keep", 64'(out_tkeep), 64'd0);
      checkOutput("rst_last", 64'(out_tlast), 64'd0);
      checkOutput("rst_cnt", 64'(wc), 64'd0);
      checkOutput("rst_ready", 64'(in_tready), 64'd1);
      @(posedge clk);
      #1;
      arst = 1'b0;
      mon_en = 1'b1;

      // One full word, visible the cycle after its last beat.
      pushWord(32'h44332211, 4'hF, 1'b0);
      applyStimulus(8'h11, 1'b0);
      applyStimulus(8'h22, 1'b0);
      applyStimulus(8'h33, 1'b0);
      applyStimulus(8'h44, 1'b0);
      checkOutput("latency_valid", 64'(out_tvalid), 64'd1);
      checkOutput("latency_data", 64'(out_tdata), 64'h44332211);
      waitDrain();
      checkOutput("cnt_one", 64'(wc), 64'd1);

      softReset();
      for (int v = 0; v < 6; v++) begin
         pushWord(vecs[v].ed, vecs[v].ek, vecs[v].el);
         for (int j = 0; j < vecs[v].nb; j++)
            applyStimulus(vecs[v].b[j], vecs[v].tl && (j == vecs[v].nb - 1));
      end
      waitDrain();
      checkOutput("cnt_table", 64'(wc), 64'd6);

      // Soft reset in the middle of a word drops the partial beats.
      softReset();
      applyStimulus(8'hE1, 1'b0);
      applyStimulus(8'hE2, 1'b0);
      softReset();
      pushWord(32'h04030201, 4'hF, 1'b0);
      for (int j = 1; j <= 4; j++) applyStimulus(8'(j), 1'b0);
      waitDrain();
      checkOutput("cnt_after_rst", 64'(wc), 64'd1);

      softReset();
      tog_en = 1'b1;
      for (int w = 0; w < 4; w++)
         pushWord({8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)}, 4'hF, 1'b0);
      for (int j = 0; j < 16; j++) applyStimulus(8'(j), 1'b0);
      waitDrain();
      tog_en = 1'b0;
      checkOutput("cnt_toggle", 64'(wc), 64'd4);

      // Async reset while a finished word is stalled.
      rdy_fixed = 1'b0;
      for (int j = 1; j <= 4; j++) applyStimulus(8'(j), 1'b0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("stalled_valid", 64'(out_tvalid), 64'd1);
      mon_en = 1'b0;
      #2 arst = 1'b1;
      #1;
      checkOutput("arst_valid", 64'(out_tvalid), 64'd0);
      checkOutput("arst_cnt", 64'(wc), 64'd0);
      checkOutput("arst_keep", 64'(out_tkeep), 64'd0);
      #2 arst = 1'b0;
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      rdy_fixed = 1'b1;
      pushWord(32'h08070605, 4'hF, 1'b0);
      for (int j = 5; j <= 8; j++) applyStimulus(8'(j), 1'b0);
      waitDrain();
      checkOutput("cnt_after_arst", 64'(wc), 64'd1);

      softReset();
      for (int w = 0; w < 17; w++) begin
         pushWord({8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)}, 4'hF, 1'b0);
         for (int j = 0; j < 4; j++) applyStimulus(8'(4*w+j), 1'b0);
      end
      waitDrain();
      checkOutput("cnt_17", 64'(wc), 64'd17);
      checkOutput("cnt4_wrap", 64'(wc4), 64'd1);

      // Clock enable dropped mid-packet freezes everything, including the offered beat.
      pushWord(32'h40302010, 4'hF, 1'b0);
      applyStimulus(8'h10, 1'b0);
      applyStimulus(8'h20, 1'b0);
      cke = 1'b0;
      in_tdata = 8'h30;
      in_tvalid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checkOutput("cke_ready", 64'(in_tready), 64'd0);
         checkOutput("cke_valid", 64'(out_tvalid), 64'd0);
         checkOutput("cke_cnt", 64'(wc), 64'd17);
      end
      @(posedge clk);
      #1;
      cke = 1'b1;
      applyStimulus(8'h30, 1'b0);
      applyStimulus(8'h40, 1'b0);
      waitDrain();
      checkOutput("cnt_cke", 64'(wc), 64'd18);
      checkOutput("cnt4_cke", 64'(wc4), 64'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/iob_axis_packer.md
Name: iob_axis_packer

Overview:
- Upstream feeder for the DMA's AXIS input path.
- Packs narrow peripheral stream beats (IN_W) into full AXI_DATA_W words for the DMA, with lane-valid mask and packet-end flush.
- One instance sits per narrow AXIS source, ahead of the DMA's input mux.
- Also counts emitted words so software can cross-check against the DMA transfer size.

Parameters:
- IN_W, 8, input beat width; OUT_W must be an integer multiple of it.
- OUT_W, 32, output word width; must equal the DMA's AXI_DATA_W.
- RATIO, OUT_W/IN_W (derived localparam), beats per word; power of two, >=1.
- CNT_W, 32, width of the emitted-word counter.

Ports:
- clk_i  in  1  clock.
- cke_i  in  1  clock enable; 0 freezes every register.
- arst_i  in  1  reset, asynchronous, active-high.
- rst_i  in  1  synchronous soft reset, active-high, qualified by cke_i.
- in_tdata_i  in  IN_W  input beat data.
- in_tvalid_i  in  1  input beat valid.
- in_tlast_i  in  1  input packet end.
- in_tready_o  out  1  input ready.
- out_tdata_o  out  OUT_W  packed word.
- out_tkeep_o  out  RATIO  lane-valid mask; bit k covers bits [k*IN_W +: IN_W].
- out_tlast_o  out  1  word closes a packet.
- out_tvalid_o  out  1  output valid.
- out_tready_i  in  1  output ready (driven by the DMA input ready).
- word_cnt_o  out  CNT_W  words accepted downstream since reset.

Behaviour:
- Registers:
  - acc: OUT_W data accumulator.
  - keep_acc: RATIO-bit mask.
  - lane: log2(RATIO) bits, min 1.
  - out_*: output holding register.
  - word_cnt.
- Reset (arst_i async, or rst_i sync with cke_i=1): acc=0, keep_acc=0, lane=0, out_tdata_o=0, out_tkeep_o=0, out_tlast_o=0, out_tvalid_o=0, word_cnt_o=0.
- Handshakes:
  - in_tready_o = cke_i & (~out_tvalid_o | out_tready_i). This is combinational from out_tready_i, which is intended.
  - Input beat accepted (acc_fire) = in_tvalid_i & in_tready_o.
  - Output transfer (out_fire) = out_tvalid_o & out_tready_i & cke_i.
- Packing is little-endian:
  - The beat on acc_fire is written into lane position lane, i.e. bits [lane*IN_W +: IN_W], and keep bit lane is set.
  - The first beat of a word lands in the LSBs.
- Word completes on acc_fire when lane==RATIO-1 or in_tlast_i==1. On the next edge:
  - out_tdata_o gets acc merged with the current beat; unfilled lanes are 0.
  - out_tkeep_o gets keep_acc merged with the current lane bit.
  - out_tlast_o gets in_tlast_i.
  - out_tvalid_o goes to 1.
  - acc, keep_acc and lane are cleared.
- Word does not complete on acc_fire: lane increments, out register unchanged.
- Latency: the word is valid the cycle after its final beat is accepted. Throughput is one input beat per cycle while downstream is ready.
- On out_fire with no new completion: out_tvalid_o goes to 0 and word_cnt increments. Simultaneous out_fire and new completion: the out register reloads, out_tvalid_o stays 1, and word_cnt increments.
- Stall: out_tvalid_o=1 and out_tready_i=0 forces in_tready_o=0. All out_* hold stable; no beat is accepted or lost.
- RATIO==1: every accepted beat completes a word, so the block is a one-stage registered pipe with out_tkeep_o=1.
- in_tlast_i on lane 0 yields a word with out_tkeep_o=...0001 and zero upper lanes.
- word_cnt_o wraps modulo 2^CNT_W.
- rst_i mid-packet discards partial acc and any pending output word; rst_i has priority over simultaneous fires.
- cke_i=0: no state change, in_tready_o=0, outputs hold.
- in_tvalid_i with in_tready_o=0 has no effect. in_tdata_i and in_tlast_i are don't-care when in_tvalid_i=0.

Test Plan:
- IN_W=8/OUT_W=32, out_tready_i=1, send 0x11,0x22,0x33,0x44 back-to-back -> one cycle after 4th beat: out_tdata_o=0x44332211, out_tkeep_o=4'b1111, out_tlast_o=0, word_cnt_o=1 after transfer.
- Send 0xAA,0xBB with tlast on 0xBB -> out_tdata_o=0x0000BBAA, out_tkeep_o=4'b0011, out_tlast_o=1; next word starts at lane 0.
- Stream 16 beats, out_tready_i toggling 1,0,0,1,... -> 4 words 0x03020100..0x0F0E0D0C in order, no drops or duplicates; in_tready_o=0 whenever out_tvalid_o=1 and out_tready_i=0; data stable during stall; word_cnt_o=4.
- Single beat 0x5A with tlast at lane 0 -> out_tdata_o=0x0000005A, out_tkeep_o=4'b0001, out_tlast_o=1.
- Two beats accepted, then rst_i=1 one cycle, then 0x01..0x04 -> first output word 0x04030201; no residue of the pre-reset beats. Same with arst_i pulse mid-stall -> out_tvalid_o=0 immediately, word_cnt_o=0.
- Preload word_cnt_o near 2^CNT_W-1 (CNT_W=4 build, 17 words) -> word_cnt_o wraps to 1; cke_i=0 for 3 cycles mid-packet -> no state change, in_tready_o=0, packing resumes correctly.
